// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter slice.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs 0..DIV-1 while enabled and pulses tick on the last count.
module uart_baud_gen #(
  parameter int DIV = 104
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] count;

  assign tick = (count == CNT_W'(DIV - 1));

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input and exact-length bits.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 1_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 2,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int DIV    = calc_div(CLK_HZ, BAUD);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1 || DIV < 2) begin : g_bad_params
    $error("uart_tx_param: illegal parameter combination");
  end

  uart_tx_state_e       state;
  logic [DATA_BITS-1:0] shreg;
  logic [BIT_W-1:0]     bit_idx;
  logic [STOP_W-1:0]    stop_idx;
  logic                 accept;
  logic                 tick;

`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  assign tx_ready = (state == IDLE) && !reset;
  assign accept   = tx_valid && tx_ready;

  // Clearing on accept makes the start bit exactly DIV cycles long.
  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .en    (state != IDLE),
    .clr   (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= '0;
      tx_out   <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_valid) begin
            state    <= START;
            shreg    <= tx_data;
            bit_idx  <= '0;
            stop_idx <= '0;
            tx_out   <= 1'b0;
            tx_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
          end
        end
        START: begin
          if (tick) begin
            state  <= DATA;
            tx_out <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state  <= PARITY;
              tx_out <= parity_q;
`else
              state  <= STOP;
              tx_out <= 1'b1;
`endif
            end else begin
              // shreg[0] is the bit on the line, so the next one is shreg[1].
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              tx_out  <= shreg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state  <= STOP;
            tx_out <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (stop_idx == STOP_W'(STOP_BITS - 1)) begin
              state   <= IDLE;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule
